// File: rtl/softmax_seq_ctrl.sv
// Two-pass softmax sequencer sharing one external exp unit and one ln unit over a buffered vector.
// Define SOFTMAX_MAXSUB_EN to subtract the vector max in pass 1 and fold it back into the ln term.
module softmax_seq_ctrl #(
  parameter int VEC_LEN = 16,
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_empty,
  output logic              in_rd_en,
  input  logic              abort,
  output logic [DATA_W-1:0] exp_arg,
  output logic [DATA_W-1:0] exp_lnf,
  input  logic [19:0]       exp_res,
  output logic [ACC_W-1:0]  ln_sum,
  input  logic [DATA_W-1:0] ln_res,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              vec_done,
  output logic [15:0]       vec_cnt
);
  localparam int IDX_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(VEC_LEN - 1);

  typedef enum logic [2:0] {IDLE, LOAD, ACCUM, LN, OUT} state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [ACC_W-1:0]  acc;
  logic [DATA_W-1:0] lnf_r;
  logic [DATA_W-1:0] elem_buf [VEC_LEN];
  logic [ACC_W:0]    acc_sum;
  logic [DATA_W-1:0] accum_lnf;
  logic [DATA_W-1:0] lnf_next;

`ifdef SOFTMAX_MAXSUB_EN
  logic [DATA_W-1:0] mx;
  logic [DATA_W:0]   mx_sum;
  assign accum_lnf = mx;
  assign mx_sum    = {mx[DATA_W-1], mx} + {ln_res[DATA_W-1], ln_res};
  // Signed saturation: overflow when the two top bits of the widened sum disagree.
  assign lnf_next  = (mx_sum[DATA_W] != mx_sum[DATA_W-1]) ?
                     (mx_sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}}) :
                     mx_sum[DATA_W-1:0];
`else
  assign accum_lnf = '0;
  assign lnf_next  = ln_res;
`endif

  assign acc_sum   = {1'b0, acc} + (ACC_W+1)'(exp_res);
  assign in_rd_en  = (state == LOAD) && !in_empty;
  assign ln_sum    = acc;
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);
  assign out_data  = (|exp_res[19:8]) ? 8'hFF : exp_res[7:0];

  always_comb begin
    exp_arg = '0;
    exp_lnf = '0;
    case (state)
      ACCUM: begin
        exp_arg = elem_buf[idx];
        exp_lnf = accum_lnf;
      end
      OUT: begin
        exp_arg = elem_buf[idx];
        exp_lnf = lnf_r;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (in_rd_en) elem_buf[idx] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      acc      <= '0;
      lnf_r    <= '0;
      vec_cnt  <= '0;
      vec_done <= 1'b0;
`ifdef SOFTMAX_MAXSUB_EN
      mx       <= {1'b1, {(DATA_W-1){1'b0}}};
`endif
    end else begin
      vec_done <= 1'b0;
      if (abort) begin
        state <= IDLE;
        idx   <= '0;
        acc   <= '0;
      end else begin
        case (state)
          IDLE: if (!in_empty) begin
            state <= LOAD;
            idx   <= '0;
`ifdef SOFTMAX_MAXSUB_EN
            mx    <= {1'b1, {(DATA_W-1){1'b0}}};
`endif
          end
          LOAD: if (!in_empty) begin
`ifdef SOFTMAX_MAXSUB_EN
            if ($signed(in_data) > $signed(mx)) mx <= in_data;
`endif
            if (idx == LAST) begin
              idx   <= '0;
              state <= ACCUM;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
          ACCUM: begin
            acc <= acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
            if (idx == LAST) begin
              idx   <= '0;
              state <= LN;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
          LN: begin
            lnf_r <= lnf_next;
            idx   <= '0;
            state <= OUT;
          end
          OUT: if (out_ready) begin
            if (idx == LAST) begin
              vec_done <= 1'b1;
              vec_cnt  <= vec_cnt + 16'd1;
              acc      <= '0;
              idx      <= '0;
              state    <= IDLE;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_softmax_seq_ctrl.sv
// Directed and randomized bench for softmax_seq_ctrl with exp/ln stubs and a vector-level reference model.
module tb_softmax_seq_ctrl;
  localparam int N = 16;

  logic        clk, rst, in_empty, abort, out_ready;
  logic [7:0]  in_data, exp_arg, exp_lnf, ln_res, out_data;
  logic [19:0] exp_res;
  logic [23:0] ln_sum;
  logic        in_rd_en, out_valid, busy, vec_done;
  logic [15:0] vec_cnt;

  int          checks, errors;
  int          stub_mode;
  logic [7:0]  ln_stub;
  logic [7:0]  elem [N];
  logic [15:0] exp_cnt;

  softmax_seq_ctrl #(.VEC_LEN(N), .DATA_W(8), .ACC_W(24)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_empty(in_empty), .in_rd_en(in_rd_en),
    .abort(abort), .exp_arg(exp_arg), .exp_lnf(exp_lnf), .exp_res(exp_res),
    .ln_sum(ln_sum), .ln_res(ln_res), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .vec_done(vec_done), .vec_cnt(vec_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] f_exp(input int mode, input logic [7:0] a, input logic [7:0] l);
    case (mode)
      0:       return {12'h0, a};
      1:       return 20'h00100;
      default: return 20'(a) * 20'(a) + 20'(l);
    endcase
  endfunction

  always_comb exp_res = f_exp(stub_mode, exp_arg, exp_lnf);
  assign ln_res = ln_stub;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_vec(input int mode, input logic [7:0] l_val, input int empty_mode,
                         input int ready_mode, input int abort_k, input int rst_beat);
    logic [7:0]  q[$];
    logic [7:0]  mx, accl, lnf, pd, pa;
    logic [7:0]  p [N];
    logic [24:0] a;
    logic [19:0] r;
    logic        stalled, finished, gate;
    int          pops, last_pop, beat, done_cyc, stall_cnt, k;
`ifdef SOFTMAX_MAXSUB_EN
    int          s;
`endif
    stub_mode = mode;
    ln_stub   = l_val;
    mx = 8'h80;
    for (int i = 0; i < N; i++) if ($signed(elem[i]) > $signed(mx)) mx = elem[i];
`ifdef SOFTMAX_MAXSUB_EN
    accl = mx;
    s = int'($signed(mx)) + int'($signed(l_val));
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    lnf = 8'(s);
`else
    accl = 8'h00;
    lnf  = l_val;
`endif
    a = '0;
    for (int i = 0; i < N; i++) begin
      a = a + 25'(f_exp(mode, elem[i], accl));
      if (a > 25'hFFFFFF) a = 25'hFFFFFF;
    end
    for (int i = 0; i < N; i++) begin
      r = f_exp(mode, elem[i], lnf);
      p[i] = (r > 20'hFF) ? 8'hFF : r[7:0];
      q.push_back(elem[i]);
    end
    pops = 0; last_pop = -100; beat = 0; done_cyc = -1; stall_cnt = 0;
    stalled = 1'b0; finished = 1'b0; pd = '0; pa = '0;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      @(negedge clk);
      case (empty_mode)
        0:       gate = 1'b0;
        1:       gate = cyc[0];
        default: gate = ($urandom_range(0, 2) == 0);
      endcase
      in_empty = (q.size() == 0) || gate;
      in_data  = (q.size() != 0) ? q[0] : 8'h00;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = !(beat == 7 && stall_cnt < 5);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      abort = (abort_k >= 0) && (pops == N) && (cyc == last_pop + 1 + abort_k);
      #1;
      check("rd_en_while_empty", 32'(in_rd_en & in_empty), 0);
      if (pops > 0 && pops < N && !in_empty) check("rd_en_in_load", 32'(in_rd_en), 1);
      check("vec_done_pulse", 32'(vec_done), 32'(cyc == done_cyc));
      k = cyc - last_pop - 1;
      if (pops == N && k >= 0 && k < N && (abort_k < 0 || k <= abort_k)) begin
        check("accum_arg", 32'(exp_arg), 32'(elem[k]));
        check("accum_lnf", 32'(exp_lnf), 32'(accl));
      end
      if (abort_k >= 0 && pops == N && k == abort_k + 1) begin
        check("abort_busy", 32'(busy), 0);
        check("abort_acc", 32'(ln_sum), 0);
        check("abort_cnt", 32'(vec_cnt), 32'(exp_cnt));
        finished = 1'b1;
      end else if (pops == N && k == N) begin
        check("ln_sum", 32'(ln_sum), 32'(a[23:0]));
        check("ln_no_valid", 32'(out_valid), 0);
      end else if (pops == N && k > N && beat < N) begin
        if (k == N + 1) check("first_valid_latency", 32'(out_valid), 1);
        check("out_valid", 32'(out_valid), 1);
        check("out_data", 32'(out_data), 32'(p[beat]));
        check("out_lnf", 32'(exp_lnf), 32'(lnf));
        if (stalled) begin
          check("stall_data", 32'(out_data), 32'(pd));
          check("stall_arg", 32'(exp_arg), 32'(pa));
        end
        if (rst_beat >= 0 && beat == rst_beat) begin
          #2 rst = 1'b1;
          #1;
          check("rst_busy", 32'(busy), 0);
          check("rst_valid", 32'(out_valid), 0);
          check("rst_acc", 32'(ln_sum), 0);
          check("rst_cnt", 32'(vec_cnt), 0);
          check("rst_arg", 32'(exp_arg), 0);
          exp_cnt = '0;
          @(posedge clk);
          @(negedge clk);
          rst = 1'b0;
          finished = 1'b1;
        end else if (out_ready) begin
          beat++;
          stalled = 1'b0;
          if (beat == N) done_cyc = cyc + 1;
        end else begin
          stalled = 1'b1;
          pd = out_data;
          pa = exp_arg;
          stall_cnt++;
        end
      end else if (cyc == done_cyc) begin
        exp_cnt = exp_cnt + 16'd1;
        check("done_busy", 32'(busy), 0);
        check("done_cnt", 32'(vec_cnt), 32'(exp_cnt));
        check("done_pops", pops, N);
        finished = 1'b1;
      end
      if (in_rd_en && q.size() != 0) begin
        void'(q.pop_front());
        pops++;
        if (pops == N) last_pop = cyc;
      end
    end
    abort = 1'b0;
    check("vector_completed_in_budget", 32'(finished), 1);
  endtask

  initial begin
    checks = 0; errors = 0; exp_cnt = '0;
    rst = 1'b1; in_empty = 1'b1; in_data = '0; abort = 1'b0; out_ready = 1'b0;
    stub_mode = 0; ln_stub = '0;
    repeat (2) @(negedge clk);
    in_empty = 1'b0;
    #1;
    check("reset_busy", 32'(busy), 0);
    check("reset_valid", 32'(out_valid), 0);
    check("reset_rd_en", 32'(in_rd_en), 0);
    check("reset_arg", 32'(exp_arg), 0);
    check("reset_lnf", 32'(exp_lnf), 0);
    check("reset_ln_sum", 32'(ln_sum), 0);
    check("reset_cnt", 32'(vec_cnt), 0);
    check("reset_done", 32'(vec_done), 0);
    @(negedge clk);
    in_empty = 1'b1;
    rst = 1'b0;

    for (int i = 0; i < N; i++) elem[i] = 8'(i);
    run_vec(0, 8'h00, 0, 0, -1, -1);
    for (int i = 0; i < N; i++) elem[i] = 8'h00;
    run_vec(1, 8'h2C, 0, 0, -1, -1);
    for (int i = 0; i < N; i++) elem[i] = 8'(i);
    run_vec(0, 8'h00, 1, 0, -1, -1);
    run_vec(0, 8'h00, 0, 1, -1, -1);
    for (int i = 0; i < N; i++) elem[i] = 8'(i + 1);
    run_vec(0, 8'h00, 0, 0, 4, -1);
    run_vec(0, 8'h00, 0, 0, -1, 5);
    run_vec(0, 8'h00, 0, 0, -1, -1);

    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < N; i++) elem[i] = 8'($urandom);
      run_vec((v % 2 == 0) ? 2 : 0, 8'($urandom), 2, 2, -1, -1);
    end

`ifdef SOFTMAX_MAXSUB_EN
    for (int i = 0; i < N; i++) elem[i] = 8'h10;
    elem[5] = 8'h30;
    run_vec(0, 8'h05, 0, 0, -1, -1);
    elem[3] = 8'h7F;
    run_vec(0, 8'h05, 0, 0, -1, -1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
